// File: rtl/sd_drive_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_drive_arbiter_if
//   Block-level SD channel between the drive arbiter and the HPS I/O bridge.
//   master : arbiter side (issues LBA + rd/wr, supplies write data)
//   slave  : bridge side (returns ack and buffer write strobes)
//   sd_lba      32  sector address
//   sd_rd/sd_wr  1  level request, held until sd_ack
//   sd_ack       1  bridge busy with the sector
//   sd_buff_wr   1  bridge strobe into the owner's sector buffer
//   sd_buff_din DW  owner's buffer data for sector writes
// ---------------------------------------------------------------------------
interface sd_drive_arbiter_if #(
  parameter int DW = 8
);
  logic [31:0]   sd_lba;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack;
  logic          sd_buff_wr;
  logic [DW-1:0] sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/sd_drive_arbiter.sv
// ---------------------------------------------------------------------------
// sd_drive_arbiter
//   Shares the single SD block channel of the HPS bridge between two virtual
//   drives. Each drive posts one sector request (rd/wr pulse + LBA); the
//   channel is granted round-robin and ack / buffer strobes / write data are
//   routed to and from the owning drive only.
//
//   clk_sys, reset            clock, synchronous active-high reset
//   drv_lba*, drv_rd*, drv_wr*  per-drive request pulse and LBA
//   drv_buff_din*             per-drive buffer data (sector write path)
//   drv_ack*, drv_buff_wr*    bridge ack / strobe gated to the owner
//   drv_done*                 one-cycle completion pulse
//   drv_busy*                 request pending or in progress
//   sd                        bridge-side channel (master modport)
// ---------------------------------------------------------------------------
module sd_drive_arbiter #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [31:0]   drv_lba0,
  input  logic [31:0]   drv_lba1,
  input  logic          drv_rd0,
  input  logic          drv_rd1,
  input  logic          drv_wr0,
  input  logic          drv_wr1,
  input  logic [DW-1:0] drv_buff_din0,
  input  logic [DW-1:0] drv_buff_din1,
  output logic          drv_ack0,
  output logic          drv_ack1,
  output logic          drv_buff_wr0,
  output logic          drv_buff_wr1,
  output logic          drv_done0,
  output logic          drv_done1,
  output logic          drv_busy0,
  output logic          drv_busy1,
  sd_drive_arbiter_if.master sd
);

  // Buffer address width is only meaningful to the drives; reject nonsense.
  if (AW < 1 || DW < 1) begin : g_bad_param
    $error("sd_drive_arbiter: AW and DW must be positive");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dir_q, dir_d;      // 1 = write
  logic [1:0][31:0] lba_q, lba_d;
  logic [31:0]      sd_lba_q, sd_lba_d;
  logic             sd_rd_q, sd_rd_d;
  logic             sd_wr_q, sd_wr_d;

  logic [1:0]          req, req_wr, active, busy, ack, bwr, done;
  logic [1:0][31:0]    req_lba;
  logic [1:0][DW-1:0]  din;
  logic                gnt_vld, gnt;

  assign req     = {drv_rd1 | drv_wr1, drv_rd0 | drv_wr0};
  // rd wins when both are pulsed together
  assign req_wr  = {drv_wr1 & ~drv_rd1, drv_wr0 & ~drv_rd0};
  assign req_lba = {drv_lba1, drv_lba0};
  assign din     = {drv_buff_din1, drv_buff_din0};

  always_comb begin
    active = '0;
    if (state_q != IDLE) active[owner_q] = 1'b1;
  end

  assign busy = pend_q | active;

  // No grant while the bridge still holds ack, so a stale ack left over
  // from an aborted transfer is never credited to the next owner.
  assign gnt_vld = (state_q == IDLE) && !sd.sd_ack && (pend_q != 2'b00);
  assign gnt     = (&pend_q) ? ~last_q : pend_q[1];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    lba_d    = lba_q;
    sd_lba_d = sd_lba_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;

    // One outstanding request per drive; extra pulses are dropped.
    for (int i = 0; i < 2; i++) begin
      if (req[i] && !busy[i]) begin
        pend_d[i] = 1'b1;
        lba_d[i]  = req_lba[i];
        dir_d[i]  = req_wr[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d     = gnt;
          last_d      = gnt;
          pend_d[gnt] = 1'b0;
          sd_lba_d    = lba_q[gnt];
          sd_rd_d     = ~dir_q[gnt];
          sd_wr_d     = dir_q[gnt];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (sd.sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!sd.sd_ack) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      pend_q   <= '0;
      dir_q    <= '0;
      lba_q    <= '0;
      sd_lba_q <= '0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      lba_q    <= lba_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
    end
  end

  // Owner-only routing of bridge strobes
  always_comb begin
    ack  = '0;
    bwr  = '0;
    done = '0;
    if (state_q == ISSUE || state_q == XFER) ack[owner_q] = sd.sd_ack;
    if (state_q == XFER) bwr[owner_q] = sd.sd_buff_wr;
    if (state_q == DONE) done[owner_q] = 1'b1;
  end

  assign {drv_ack1, drv_ack0}         = ack;
  assign {drv_buff_wr1, drv_buff_wr0} = bwr;
  assign {drv_done1, drv_done0}       = done;
  assign {drv_busy1, drv_busy0}       = busy;

  assign sd.sd_lba      = sd_lba_q;
  assign sd.sd_rd       = sd_rd_q;
  assign sd.sd_wr       = sd_wr_q;
  assign sd.sd_buff_din = din[owner_q];

endmodule

// File: tb/tb_sd_drive_arbiter.sv
`timescale 1ns/1ps
module tb_sd_drive_arbiter;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic [31:0] drv_lba0, drv_lba1;
  logic        drv_rd0, drv_rd1, drv_wr0, drv_wr1;
  logic [7:0]  drv_buff_din0, drv_buff_din1;
  logic        drv_ack0, drv_ack1, drv_buff_wr0, drv_buff_wr1;
  logic        drv_done0, drv_done1, drv_busy0, drv_busy1;

  sd_drive_arbiter_if #(.DW(8)) sd ();

  // Bridge ack/strobe come from the automatic responder or, in the reset
  // scenario, directly from the stimulus process.
  logic bridge_en, br_ack, br_bw, st_ack, st_bw;
  assign sd.sd_ack     = bridge_en ? br_ack : st_ack;
  assign sd.sd_buff_wr = bridge_en ? br_bw  : st_bw;

  sd_drive_arbiter #(.AW(9), .DW(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .drv_lba0(drv_lba0), .drv_lba1(drv_lba1),
    .drv_rd0(drv_rd0), .drv_rd1(drv_rd1),
    .drv_wr0(drv_wr0), .drv_wr1(drv_wr1),
    .drv_buff_din0(drv_buff_din0), .drv_buff_din1(drv_buff_din1),
    .drv_ack0(drv_ack0), .drv_ack1(drv_ack1),
    .drv_buff_wr0(drv_buff_wr0), .drv_buff_wr1(drv_buff_wr1),
    .drv_done0(drv_done0), .drv_done1(drv_done1),
    .drv_busy0(drv_busy0), .drv_busy1(drv_busy1),
    .sd(sd)
  );

  typedef struct {
    int          drv;
    logic [31:0] lba;
    logic        dir;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0, errors = 0;
  int   issued_cnt = 0, done_cnt = 0;
  int   mon_drv = 0;
  int   strobes_sent = 0;
  logic mon_inflight = 1'b0;
  logic in_xfer = 1'b0;
  logic big_xfer = 1'b0;
  int   last_gnt = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic cmd_prev;
    int   bw0, bw1;
    txn_t e;
    cmd_prev = 1'b0; bw0 = 0; bw1 = 0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_inflight = 1'b0;
        cmd_prev     = 1'b0;
      end else begin
        if ((sd.sd_rd || sd.sd_wr) && !cmd_prev) begin
          chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("issue_lba", sd.sd_lba, e.lba);
            chk("issue_rd", 32'(sd.sd_rd), 32'(!e.dir));
            chk("issue_wr", 32'(sd.sd_wr), 32'(e.dir));
            mon_drv      = e.drv;
            mon_inflight = 1'b1;
            bw0 = 0; bw1 = 0;
          end
        end
        cmd_prev = sd.sd_rd || sd.sd_wr;
        if (mon_inflight) begin
          chk("ack_owner", 32'(mon_drv != 0 ? drv_ack1 : drv_ack0), 32'(sd.sd_ack));
          chk("ack_other", 32'(mon_drv != 0 ? drv_ack0 : drv_ack1), 32'd0);
        end else begin
          chk("ack_idle", 32'({drv_ack1, drv_ack0}), 32'd0);
          chk("bw_idle", 32'({drv_buff_wr1, drv_buff_wr0}), 32'd0);
        end
        bw0 += 32'(drv_buff_wr0);
        bw1 += 32'(drv_buff_wr1);
        if (drv_done0 || drv_done1) begin
          if (!mon_inflight) begin
            chk("unexpected_done", 32'({drv_done1, drv_done0}), 32'd0);
          end else begin
            chk("done_drive", 32'({drv_done1, drv_done0}), (mon_drv != 0) ? 32'd2 : 32'd1);
            chk("bw_owner_count", (mon_drv != 0) ? bw1 : bw0, strobes_sent);
            chk("bw_other_count", (mon_drv != 0) ? bw0 : bw1, 32'd0);
            mon_inflight = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  // ---------------- bridge responder ----------------
  initial begin
    br_ack = 1'b0; br_bw = 1'b0;
    drv_buff_din0 = '0; drv_buff_din1 = '0;
    forever begin
      @(negedge clk_sys);
      if (bridge_en && !reset && (sd.sd_rd || sd.sd_wr)) begin
        int n;
        repeat ($urandom_range(0, 3)) @(posedge clk_sys);
        @(posedge clk_sys); #1 br_ack = 1'b1;
        @(posedge clk_sys); #1;
        chk("cmd_drop_with_ack", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
        n = big_xfer ? 512 : int'($urandom_range(6, 16));
        strobes_sent = n;
        in_xfer = 1'b1;
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk_sys); #1; end
          br_bw = 1'b1;
          if (k == 0) begin
            drv_buff_din0 = 8'h3C; drv_buff_din1 = 8'hA5;
          end else begin
            drv_buff_din0 = 8'($urandom); drv_buff_din1 = 8'($urandom);
          end
          #1 chk("buff_din_mux", 32'(sd.sd_buff_din),
                 32'(mon_drv != 0 ? drv_buff_din1 : drv_buff_din0));
          @(posedge clk_sys); #1 br_bw = 1'b0;
        end
        in_xfer = 1'b0;
        br_ack  = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic clr_req();
    drv_rd0 = 1'b0; drv_wr0 = 1'b0; drv_rd1 = 1'b0; drv_wr1 = 1'b0;
  endtask

  // kind: 0 = read, 1 = write, 2 = rd and wr together
  task automatic set_req(input int d, input logic [31:0] lba, input int kind);
    if (d == 0) begin
      drv_lba0 = lba; drv_rd0 = (kind != 1); drv_wr0 = (kind != 0);
    end else begin
      drv_lba1 = lba; drv_rd1 = (kind != 1); drv_wr1 = (kind != 0);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] lba, input int kind);
    txn_t t;
    t.drv = d; t.lba = lba; t.dir = (kind == 1);
    exp_q.push_back(t);
    issued_cnt++;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (done_cnt != issued_cnt && t < 5000) begin tick(); t++; end
    if (t >= 5000) chk("drain_timeout", done_cnt, issued_cnt);
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("busy_idle", 32'({drv_busy1, drv_busy0}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_req();
    tick(); tick();
    reset = 1'b0;
    last_gnt = 1;
  endtask

  // Issue one batch of requests and predict the service order:
  // a lone request is served; simultaneous requests go to the drive that
  // did not win last; a request that arrives later queues behind.
  task automatic issue_batch(input logic [1:0] sel, input logic [31:0] l0, input logic [31:0] l1,
                             input int k0, input int k1, input int d, input int first,
                             input logic [1:0] dup, input logic mid);
    int off[2];
    int a, ncyc, t;
    if (sel == 2'b11) begin
      a = (d == 0) ? ((last_gnt == 0) ? 1 : 0) : first;
      push_exp(a, (a != 0) ? l1 : l0, (a != 0) ? k1 : k0);
      push_exp(1 - a, (a != 0) ? l0 : l1, (a != 0) ? k0 : k1);
      last_gnt = 1 - a;
      off[a] = 0; off[1 - a] = d;
      ncyc = d + 2;
    end else begin
      a = sel[1] ? 1 : 0;
      push_exp(a, (a != 0) ? l1 : l0, (a != 0) ? k1 : k0);
      last_gnt = a;
      off[a] = 0; off[1 - a] = 99;
      ncyc = 2;
    end
    for (int c = 0; c < ncyc; c++) begin
      clr_req();
      for (int i = 0; i < 2; i++) begin
        if (sel[i] && c == off[i])
          set_req(i, (i != 0) ? l1 : l0, (i != 0) ? k1 : k0);
        else if (sel[i] && dup[i] && c == off[i] + 1)
          set_req(i, $urandom, int'($urandom_range(0, 2)));
      end
      tick();
    end
    clr_req();
    if (mid) begin
      t = 0;
      while (!in_xfer && t < 300) begin tick(); t++; end
      if (t >= 300) chk("mid_xfer_timeout", 32'(in_xfer), 32'd1);
      else begin
        set_req(mon_drv, $urandom, 0);
        tick();
        clr_req();
      end
    end
  endtask

  initial begin
    logic [31:0] rl;
    int t;
    reset = 1'b1; bridge_en = 1'b1; st_ack = 1'b0; st_bw = 1'b0;
    drv_lba0 = '0; drv_lba1 = '0; clr_req();
    drv_rd1 = 1'b1;               // pulse while in reset must be dropped
    repeat (3) tick();
    chk("rst_cmd", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
    chk("rst_lba", sd.sd_lba, 32'd0);
    chk("rst_busy", 32'({drv_busy1, drv_busy0}), 32'd0);
    chk("rst_done", 32'({drv_done1, drv_done0}), 32'd0);
    chk("rst_ack", 32'({drv_ack1, drv_ack0}), 32'd0);
    chk("rst_bw", 32'({drv_buff_wr1, drv_buff_wr0}), 32'd0);
    clr_req();
    reset = 1'b0;
    tick();
    chk("rst_pulse_dropped", 32'(drv_busy1), 32'd0);

    // single 512-byte read with grant latency
    big_xfer = 1'b1;
    set_req(0, 32'h0000_1234, 0); push_exp(0, 32'h0000_1234, 0); last_gnt = 0;
    tick(); clr_req();
    chk("lat_busy0", 32'(drv_busy0), 32'd1);
    chk("lat_not_yet", 32'(sd.sd_rd), 32'd0);
    tick();
    chk("lat_rd", 32'(sd.sd_rd), 32'd1);
    chk("lat_lba", sd.sd_lba, 32'h0000_1234);
    chk("lat_busy1", 32'(drv_busy1), 32'd0);
    wait_idle();
    big_xfer = 1'b0;

    // tie after reset: drive 0 first, then drive 1 write
    do_reset();
    issue_batch(2'b11, 32'h0000_0A00, 32'h0000_0B11, 0, 1, 0, 0, 2'b00, 1'b0);
    wait_idle();
    issue_batch(2'b11, 32'h0000_0C22, 32'h0000_0D33, 1, 0, 0, 0, 2'b00, 1'b0);
    wait_idle();
    // drive 0 alone, then a tie goes to drive 1
    issue_batch(2'b01, 32'h0000_0005, 32'h0, 0, 0, 0, 0, 2'b01, 1'b1);
    wait_idle();
    issue_batch(2'b11, 32'h0000_0E44, 32'h0000_0F55, 0, 1, 0, 0, 2'b00, 1'b0);
    wait_idle();
    // rd+wr together on drive 1 is a read
    issue_batch(2'b10, 32'h0, 32'h0000_7777, 0, 2, 0, 0, 2'b00, 1'b0);
    wait_idle();

    // reset in the middle of a transfer with ack held high
    do_reset();
    bridge_en = 1'b0; st_ack = 1'b0;
    rl = $urandom;
    set_req(0, rl, 0); push_exp(0, rl, 0); last_gnt = 0;
    tick(); clr_req();
    t = 0;
    while (!sd.sd_rd && t < 20) begin tick(); t++; end
    chk("rst_issue_seen", 32'(sd.sd_rd), 32'd1);
    st_ack = 1'b1;
    tick();
    set_req(1, $urandom, 1);
    tick(); clr_req();
    chk("rst_pend1_busy", 32'(drv_busy1), 32'd1);
    st_bw = 1'b1; tick(); tick(); st_bw = 1'b0;
    reset = 1'b1; set_req(0, $urandom, 1);
    tick();
    reset = 1'b0; clr_req();
    issued_cnt--;
    last_gnt = 1;
    for (int c = 0; c < 10; c++) begin
      chk("abort_cmd", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
      chk("abort_busy", 32'({drv_busy1, drv_busy0}), 32'd0);
      chk("abort_done", 32'({drv_done1, drv_done0}), 32'd0);
      tick();
    end
    rl = $urandom;
    set_req(1, rl, 0); push_exp(1, rl, 0); last_gnt = 1;
    tick(); clr_req();
    for (int c = 0; c < 3; c++) begin
      chk("stale_ack_no_grant", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
      chk("stale_ack_busy1", 32'(drv_busy1), 32'd1);
      tick();
    end
    st_ack = 1'b0; bridge_en = 1'b1;
    wait_idle();

    // randomized batches
    for (int it = 0; it < 30; it++) begin
      issue_batch(2'($urandom_range(1, 3)), $urandom, $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Shares the single SD block-level channel of the HPS I/O bridge between two virtual drives (disk1 and disk2 of the SAM Coupé core).
- Captures per-drive sector read/write requests, grants the channel round-robin and drives sd_lba/sd_rd/sd_wr.
- Routes sd_ack, buffer write strobes and buffer read data to and from the owning drive only.
- Sits between the drive controllers and the HPS I/O bridge.

Parameters:
AW, 9, width of sd_buff_addr (512-byte sector, byte mode)
DW, 8, width of sd buffer data

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
drv_lba0, drv_lba1  in  32  sector LBA; sampled with the request pulse
drv_rd0, drv_rd1  in  1  one-cycle read request pulse
drv_wr0, drv_wr1  in  1  one-cycle write request pulse
drv_buff_din0, drv_buff_din1  in  DW  drive buffer read data (sector write path)
drv_ack0, drv_ack1  out  1  sd_ack gated to owner
drv_buff_wr0, drv_buff_wr1  out  1  sd_buff_wr gated to owner
drv_done0, drv_done1  out  1  one-cycle pulse at transfer completion
drv_busy0, drv_busy1  out  1  request pending or in progress
sd_lba  out  32  to bridge
sd_rd, sd_wr  out  1  to bridge, level
sd_ack  in  1  from bridge
sd_buff_wr  in  1  from bridge
sd_buff_din  out  DW  to bridge: owner's drv_buff_din (combinational mux)

sd_buff_addr and sd_buff_dout from the bridge fan out directly to both drives and are not ports of this block.

Behaviour:
- Reset values: all outputs 0; pending flags cleared; state IDLE; last_grant = 1, so drive 0 wins the first tie.
- Request capture, per drive:
  - A rd or wr pulse sets pend_i, latches lba_i, and latches dir_i (1 = write).
  - rd and wr in the same cycle: treated as read.
  - A pulse while pend_i is already set, or while drive i is the active owner: ignored. No overwrite, no queueing.
  - A pulse in the same cycle that reset is high: dropped.
- drv_busy_i = pend_i OR (owner == i AND state != IDLE).
- State machine:
  - IDLE:
    - Stays in IDLE while sd_ack = 1, so a stale ack after reset is never misattributed.
    - Otherwise, if any pend_i is set, grants a drive:
      - One pending: that drive.
      - Both pending: the drive != last_grant.
    - On grant: owner <= granted drive; last_grant <= owner; clear that drive's pend; sd_lba <= lba; sd_rd or sd_wr <= 1 per dir; go to ISSUE.
  - ISSUE:
    - Hold sd_lba, sd_rd, sd_wr.
    - On sd_ack = 1: clear sd_rd/sd_wr on the same edge and go to XFER.
    - No timeout.
  - XFER: on sd_ack = 0, go to DONE.
  - DONE: pulse drv_done_owner for 1 cycle, then return to IDLE.
- Latency: a pulse sampled at edge T gives pend at T. With the channel idle and sd_ack low, the grant occurs at edge T+1, so sd_rd/sd_wr is high from T+1.
- Routing, combinational, owner only:
  - drv_ack_i = sd_ack AND owner == i AND state in {ISSUE, XFER}.
  - drv_buff_wr_i = sd_buff_wr AND owner == i AND state == XFER.
  - sd_buff_din = drv_buff_din_owner.
  - The non-owner sees 0 on both strobes.
- sd_lba holds its last value outside ISSUE.
- Reset mid-transfer:
  - Aborts immediately: sd_rd/sd_wr 0, state IDLE, no done pulse.
  - If the bridge still holds sd_ack, no new grant is issued until it drops.

Test Plan:
- Single read: drv_rd0 with lba 0x00001234 → sd_rd = 1 one cycle later with sd_lba = 0x1234. Bridge asserts sd_ack plus 512 sd_buff_wr strobes → sd_rd drops with ack; 512 drv_buff_wr0 pulses, 0 on drv_buff_wr1; drv_done0 pulses once after ack falls.
- Simultaneous: drv_rd0 and drv_wr1 in the same cycle after reset → drive 0 served first (sd_rd). Drive 1 then gets sd_wr with lba1 without reissuing. Next tie is won by drive 0 again only after drive 1 has been served.
- Write data path: owner = 1 in XFER, drv_buff_din1 = 0xA5, drv_buff_din0 = 0x3C → sd_buff_din = 0xA5.
- Duplicate/overlap: drv_rd0 lba 5, then drv_rd0 lba 9 while pend0 is set → only lba 5 is transferred. A drv_rd0 pulse during XFER of drive 0 → ignored; drv_busy0 falls after done.
- Reset mid-XFER with sd_ack held high 10 cycles and pend1 set before reset → no done pulse, pend1 cleared, sd_rd/sd_wr stay 0 until a new request arrives after sd_ack falls.
- rd and wr pulsed together on drive 1 → sd_rd = 1, sd_wr = 0.
